// File: rtl/pipe_pkg.sv
// Shared encodings for the execute stage: ALU operation codes and divider FSM states.
`timescale 1ns/1ps
package pipe_pkg;

    localparam logic [3:0] ALUC_ADDU = 4'b0000;
    localparam logic [3:0] ALUC_SUBU = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_SUB  = 4'b0011;
    localparam logic [3:0] ALUC_AND  = 4'b0100;
    localparam logic [3:0] ALUC_OR   = 4'b0101;
    localparam logic [3:0] ALUC_XOR  = 4'b0110;
    localparam logic [3:0] ALUC_NOR  = 4'b0111;
    localparam logic [3:0] ALUC_LUI  = 4'b1000;
    localparam logic [3:0] ALUC_SLTU = 4'b1010;
    localparam logic [3:0] ALUC_SLT  = 4'b1011;
    localparam logic [3:0] ALUC_SRA  = 4'b1101;
    localparam logic [3:0] ALUC_SLL  = 4'b1110;
    localparam logic [3:0] ALUC_SRL  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/pipe_exe_unit_if.sv
// ID/EXE operand bundle into the execute stage and its results toward EXE/MEM.
`timescale 1ns/1ps
interface pipe_exe_unit_if;

    logic [3:0]  Ealuc;
    logic [31:0] Ea;
    logic [31:0] Eb;
    logic        Easource;
    logic        Ebsource;
    logic [31:0] Eimm;
    logic        Ediv;
    logic        Esign;
    logic [31:0] Ealu_r;
    logic [31:0] Ediv_q;
    logic [31:0] Ediv_r;
    logic        Ediv_done;
    logic        Estall;

    modport master (
        output Ealuc, Ea, Eb, Easource, Ebsource, Eimm, Ediv, Esign,
        input  Ealu_r, Ediv_q, Ediv_r, Ediv_done, Estall
    );

    modport slave (
        input  Ealuc, Ea, Eb, Easource, Ebsource, Eimm, Ediv, Esign,
        output Ealu_r, Ediv_q, Ediv_r, Ediv_done, Estall
    );

endinterface

// File: rtl/pipe_div_seq.sv
// 32-step restoring divider on operand magnitudes, with sign fix-up and divide-by-zero override.
`timescale 1ns/1ps
module pipe_div_seq
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        div_i,
    input  logic        sign_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] q_o,
    output logic [31:0] r_o,
    output logic        done_o
);

    div_state_t  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic [31:0] raw_a_q, raw_a_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_x_q, sign_x_d;
    logic        dz_q, dz_d;
    logic [63:0] rq_q, rq_d;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        raw_a_d  = raw_a_q;
        sign_a_d = sign_a_q;
        sign_x_d = sign_x_q;
        dz_d     = dz_q;
        rq_d     = rq_q;
        // Dividend bits are fed MSB-first from the latched magnitude, not preloaded into rq.
        rem_sh   = {rq_q[63:32], mag_a_q[5'd31 - cnt_q]};
        trial    = rem_sh - {1'b0, mag_b_q};
        case (state_q)
            IDLE: begin
                if (div_i) begin
                    mag_a_d  = (sign_i && a_i[31]) ? -a_i : a_i;
                    mag_b_d  = (sign_i && b_i[31]) ? -b_i : b_i;
                    raw_a_d  = a_i;
                    sign_a_d = sign_i & a_i[31];
                    sign_x_d = sign_i & (a_i[31] ^ b_i[31]);
                    dz_d     = (b_i == '0);
                    rq_d     = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (!div_i) begin
                    state_d = IDLE;
                end else begin
                    // Borrow out of the 33-bit trial means the restored value is kept.
                    if (!trial[32]) begin
                        rq_d = {trial[31:0], rq_q[30:0], 1'b1};
                    end else begin
                        rq_d = {rem_sh[31:0], rq_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            raw_a_q  <= '0;
            sign_a_q <= 1'b0;
            sign_x_q <= 1'b0;
            dz_q     <= 1'b0;
            rq_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            raw_a_q  <= raw_a_d;
            sign_a_q <= sign_a_d;
            sign_x_q <= sign_x_d;
            dz_q     <= dz_d;
            rq_q     <= rq_d;
        end
    end

    always_comb begin
        quo    = rq_q[31:0];
        rem    = rq_q[63:32];
        q_o    = dz_q ? '1 : (sign_x_q ? -quo : quo);
        r_o    = dz_q ? raw_a_q : (sign_a_q ? -rem : rem);
        done_o = (state_q == DONE);
    end

endmodule

// File: rtl/pipe_exe_unit.sv
// Execute stage: operand selection, single-cycle ALU, and the stalling sequential divider.
`timescale 1ns/1ps
module pipe_exe_unit
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    pipe_exe_unit_if.slave  exe
);

    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] alu_r;
    logic             div_done;

    always_comb begin
        a_src = exe.Easource ? {{(WIDTH-5){1'b0}}, exe.Eimm[10:6]} : exe.Ea;
        b_src = exe.Ebsource ? exe.Eimm : exe.Eb;
    end

    always_comb begin
        alu_r = '0;
        case (exe.Ealuc)
            ALUC_ADDU, ALUC_ADD: alu_r = a_src + b_src;
            ALUC_SUBU, ALUC_SUB: alu_r = a_src - b_src;
            ALUC_AND:            alu_r = a_src & b_src;
            ALUC_OR:             alu_r = a_src | b_src;
            ALUC_XOR:            alu_r = a_src ^ b_src;
            ALUC_NOR:            alu_r = ~(a_src | b_src);
            ALUC_LUI:            alu_r = {b_src[15:0], 16'h0000};
            ALUC_SLTU:           alu_r = {{(WIDTH-1){1'b0}}, a_src < b_src};
            ALUC_SLT:            alu_r = {{(WIDTH-1){1'b0}}, $signed(a_src) < $signed(b_src)};
            ALUC_SRA:            alu_r = $signed(b_src) >>> a_src[4:0];
            ALUC_SLL:            alu_r = b_src << a_src[4:0];
            ALUC_SRL:            alu_r = b_src >> a_src[4:0];
            default:             alu_r = '0;
        endcase
    end

    pipe_div_seq u_div (
        .clk    (clk),
        .rst    (rst),
        .div_i  (exe.Ediv),
        .sign_i (exe.Esign),
        .a_i    (a_src),
        .b_i    (b_src),
        .q_o    (exe.Ediv_q),
        .r_o    (exe.Ediv_r),
        .done_o (div_done)
    );

    assign exe.Ealu_r    = alu_r;
    assign exe.Ediv_done = div_done;
    assign exe.Estall    = exe.Ediv & ~div_done;

endmodule

// File: doc/pipe_exe_unit.md
# pipe_exe_unit

Execute stage of the dynamic pipeline CPU. Consumes the ID/EXE register outputs and produces the ALU result and divide results for the EXE/MEM register. Contains a 32-iteration sequential divider that stalls the front of the pipeline while a DIV/DIVU is in flight.

## Interface
Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Ealuc  in  4  ALU operation code; encodings in pipe_pkg.
- Ea  in  32  forwarded rs value.
- Eb  in  32  forwarded rt value.
- Easource  in  1  1: A = {27'b0, Eimm[10:6]} (shamt); 0: A = Ea.
- Ebsource  in  1  1: B = Eimm; 0: B = Eb.
- Eimm  in  32  extended immediate.
- Ediv  in  1  current EXE instruction is DIV/DIVU.
- Esign  in  1  1: signed divide; 0: unsigned.
- Ealu_r  out  32  ALU result, combinational from A, B, Ealuc.
- Ediv_q  out  32  quotient (lo); valid only while Ediv_done = 1.
- Ediv_r  out  32  remainder (hi); valid only while Ediv_done = 1.
- Ediv_done  out  1  divide result valid this cycle.
- Estall  out  1  hold PC, IF/ID and ID/EXE; insert bubble into EXE/MEM.

## Operation
- ALU: ADDU 0000, SUBU 0001, ADD 0010, SUB 0011, AND 0100, OR 0101, XOR 0110, NOR 0111, LUI 1000 (B<<16), SLTU 1010, SLT 1011, SRA 1101 (B>>>A[4:0]), SLL 1110, SRL 1111. Unused codes yield 0. No overflow trap; ADD/SUB behave as ADDU/SUBU.
- Divider FSM states IDLE, RUN, DONE.
- IDLE: if Ediv = 1, latch |A| and |B| (magnitudes when Esign = 1, raw otherwise), sign of A, sign of (A xor B), and a divide-by-zero flag (B == 0); clear the 64-bit remainder/quotient shift register and the 5-bit counter; go to RUN.
- RUN: one restoring step per cycle (shift left, trial subtract, set quotient bit). The counter increments 0..31; at count 31 go to DONE.
- DONE: Ediv_done = 1; go to IDLE unconditionally.
- Sign fix, combinational from registered magnitudes: quotient negated when the signs differ; remainder takes the sign of the dividend.
- Divide by zero: Ediv_q = 32'hFFFF_FFFF and Ediv_r = A (raw), for both signed and unsigned.
- Signed 0x8000_0000 / -1: Ediv_q = 0x8000_0000 and Ediv_r = 0, from the natural magnitude arithmetic.
- Estall = Ediv & (state != DONE).
- A, B and Esign are not re-sampled after IDLE. The ID/EXE register holds them because of Estall.

## Timing
- Reset, synchronous: state = IDLE, counter = 0, all divider registers = 0. Ediv_done = 0, Ediv_q = 0, Ediv_r = 0. Estall follows Ediv, which is 0 after the upstream register resets.
- Divide issued (Ediv = 1 in IDLE) at cycle T:
  - Estall = 1 for cycles T..T+32 (33 cycles).
  - DONE occurs at T+33 with Estall = 0.
  - The EXE/MEM register captures the results at the end of T+33.
- Back-to-back divides: the second DIV enters EXE at T+34, sees IDLE, and starts. No result from the first divide is reused.
- Ediv falling in RUN (flush): abort to IDLE on the next edge. No Ediv_done is issued.
- rst during RUN: IDLE on the next edge. Any partial result is discarded.
- Non-divide instructions: zero added latency; Ealu_r is valid in the same cycle.

## Structure
- pipe_pkg holds the ALUC_* localparams and the div_state_t enum (IDLE, RUN, DONE).
- Sub-module pipe_div_seq contains the FSM, the counter, the shift register and the sign fix. pipe_exe_unit holds the operand muxes, the ALU, and the Estall/Ediv_done wiring.

## Test plan
- Reset: assert rst for 2 cycles with Ediv = 1 -> Ediv_done = 0, Ediv_q = 0, and FSM in IDLE after release.
- ALU sweep with A = 0xF000_000F, B = 0x0000_0004:
  - ADDU -> 0xF000_0013
  - SLT -> 1
  - SLTU -> 0
  - Easource = 1, Eimm[10:6] = 4, SRA on B = 0x8000_0000 -> 0xF800_0000
- Signed divide -7 / 2 -> Estall high for exactly 33 cycles, then Ediv_q = 0xFFFF_FFFD and Ediv_r = 0xFFFF_FFFF in the Ediv_done cycle.
- Unsigned 0xFFFF_FFFF / 0x10 -> Ediv_q = 0x0FFF_FFFF, Ediv_r = 0xF. Divide by zero with A = 5 -> Ediv_q = 0xFFFF_FFFF, Ediv_r = 5.
- Signed 0x8000_0000 / 0xFFFF_FFFF -> Ediv_q = 0x8000_0000, Ediv_r = 0. An immediately following DIVU 9 / 3 -> second Ediv_done 34 cycles after the first with Ediv_q = 3.
- Abort: drop Ediv at RUN count 10, and separately assert rst at RUN count 20 -> IDLE on the next edge, Estall = 0, no Ediv_done pulse.
